// File: rtl/priority_server8_if.sv
// Request/grant handshake bundle for priority_server8.
// out_idx is present only when PRIORITY_SERVER8_IDX_EN is defined.
interface priority_server8_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_req;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_grant;
    logic       out_last;
    logic       busy;
`ifdef PRIORITY_SERVER8_IDX_EN
    logic [2:0] out_idx;
`endif

    modport master (
        output in_valid,
        output in_req,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_grant,
        input  out_last,
`ifdef PRIORITY_SERVER8_IDX_EN
        input  out_idx,
`endif
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_req,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_grant,
        output out_last,
`ifdef PRIORITY_SERVER8_IDX_EN
        output out_idx,
`endif
        output busy
    );
endinterface

// File: rtl/priority_server8.sv
// Loads an 8-bit request mask and grants its set bits one per handshake, bit 7 first.
// Optional binary grant index output is enabled by defining PRIORITY_SERVER8_IDX_EN.
module priority_server8 (
    input  logic              clk,
    input  logic              reset,
    priority_server8_if.slave bus
);

    typedef enum logic {
        IDLE,
        SERVE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] grant;
    logic       last;

    // Highest set bit wins because the ascending loop overwrites lower hits.
    always_comb begin
        grant = '0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    // pending_q is zero in IDLE, so the state term keeps out_last low there.
    assign last = (state_q == SERVE) && (pending_q == grant);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d       = state_q;
        pending_d     = pending_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                // An all-zero mask is consumed here and simply dropped.
                if (bus.in_valid && (bus.in_req != 8'h00)) begin
                    pending_d = bus.in_req;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) begin
                    pending_d = pending_q & ~grant;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    assign bus.out_grant = grant;
    assign bus.out_last  = last;

    // NOTE: sequential state uses non-blocking assignments; async reset abandons any mask at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef PRIORITY_SERVER8_IDX_EN
    logic [2:0] idx;

    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (grant[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign bus.out_idx = idx;
`else
    // Index output absent in this build; grant encoding is unchanged.
`endif

endmodule

// File: tb/tb_priority_server8.sv
// Scoreboard bench for priority_server8: expected grants are queued when a mask is
// offered and popped on every observed out_valid/out_ready handshake.
module tb_priority_server8;

    logic clk;
    logic reset;

    priority_server8_if bus ();

    priority_server8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] grant;
        logic       last;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference order: descending set bits, last flagged when nothing remains.
    task automatic push_model(input logic [7:0] mask, input int max_grants);
        logic [7:0] rem;
        int         pushed;
        exp_t       e;
        rem    = mask;
        pushed = 0;
        for (int b = 7; b >= 0; b--) begin
            if (rem[b] && pushed < max_grants) begin
                rem[b]   = 1'b0;
                e.grant  = '0;
                e.grant[b] = 1'b1;
                e.last   = (rem == 8'h00);
                e.idx    = 3'(b);
                exp_q.push_back(e);
                pushed++;
            end
        end
    endtask

    // Caller is aligned at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic send(input logic [7:0] mask, input int max_grants);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_req   = mask;
        push_model(mask, max_grants);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_req   = 8'h00;
    endtask

    // Handshake monitor: scoreboard compare plus stall stability.
    logic       stall_q = 1'b0;
    logic [7:0] held_grant = '0;
    logic       held_last = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            stall_q = 1'b0;
        end else begin
            if (bus.out_valid && stall_q) begin
                check("stall_grant_stable", 32'(bus.out_grant), 32'(held_grant));
                check("stall_last_stable", 32'(bus.out_last), 32'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(bus.out_grant), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", 32'(bus.out_grant), 32'(e.grant));
                    check("last", 32'(bus.out_last), 32'(e.last));
`ifdef PRIORITY_SERVER8_IDX_EN
                    check("idx", 32'(bus.out_idx), 32'(e.idx));
`endif
                end
            end
            stall_q    = bus.out_valid && !bus.out_ready;
            held_grant = bus.out_grant;
            held_last  = bus.out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_grant"}, 32'(bus.out_grant), 32'd0);
        check({tag, "_last"}, 32'(bus.out_last), 32'd0);
`ifdef PRIORITY_SERVER8_IDX_EN
        check({tag, "_idx"}, 32'(bus.out_idx), 32'd0);
`endif
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_req   = 8'h00;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Four grants back to back, last only on the fourth, idle on the fifth.
        bus.out_ready = 1'b1;
        send(8'b1001_0011, 8);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("burst_valid", 32'(bus.out_valid), 32'd1);
            check("burst_last", 32'(bus.out_last), 32'(k == 3));
            check("burst_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        check_idle("burst_done");
        @(posedge clk);
        #1;

        // Empty mask is consumed without any grant.
        send(8'h00, 8);
        @(negedge clk);
        check_idle("zero_mask");
        @(posedge clk);
        #1;

        // Backpressure: grant must hold for three stalled cycles.
        bus.out_ready = 1'b0;
        send(8'b0101_0000, 8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_grant", 32'(bus.out_grant), 32'h40);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_last", 32'(bus.out_last), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("resume_grant0", 32'(bus.out_grant), 32'h40);
        @(negedge clk);
        check("resume_grant1", 32'(bus.out_grant), 32'h10);
        check("resume_last1", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        check_idle("stall_done");
        @(posedge clk);
        #1;

        // Reset mid-serve after two grants.
        send(8'hFF, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_idle("mid_reset");
        repeat (2) @(negedge clk);
        check_idle("mid_reset_hold");
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_no_valid", 32'(bus.out_valid), 32'd0);
        end
        check("post_reset_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // New request offered during SERVE is ignored.
        send(8'b1100_0000, 8);
        bus.in_valid = 1'b1;
        bus.in_req   = 8'b0000_0100;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_req   = 8'h00;
        @(negedge clk);
        check_idle("ignore_done");
        check("ignore_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Index output sequence 5 then 2.
        send(8'b0010_0100, 8);
        @(negedge clk);
        check("idx_mask_grant0", 32'(bus.out_grant), 32'h20);
`ifdef PRIORITY_SERVER8_IDX_EN
        check("idx_first", 32'(bus.out_idx), 32'd5);
`endif
        @(negedge clk);
        check("idx_mask_grant1", 32'(bus.out_grant), 32'h04);
`ifdef PRIORITY_SERVER8_IDX_EN
        check("idx_second", 32'(bus.out_idx), 32'd2);
`endif
        @(posedge clk);
        #1;

        // Random masks under random backpressure.
        for (int t = 0; t < 12; t++) begin
            send(8'($urandom_range(0, 255)), 8);
            n = 0;
            while (!bus.in_ready && n < 200) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                n++;
            end
            check("random_drain", 32'(bus.in_ready), 32'd1);
            bus.out_ready = 1'b1;
        end

        repeat (2) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
